// File: rtl/writeback_unit.sv
// Writeback stage: 2-entry result FIFO draining into a registered write port, one cycle from accept
// to write when empty; Hold stalls the drain and In_ready drops only while full and held.
module writeback_unit #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            In_valid,
  output logic            In_ready,
  input  logic            In_RegWrite,
  input  logic            In_MemtoReg,
  input  logic [4:0]      In_Rd,
  input  logic [XLEN-1:0] In_ALU_result,
  input  logic [XLEN-1:0] In_Load_data,
  input  logic            Hold,
  output logic            RegWrite,
  output logic [4:0]      Rd,
  output logic [XLEN-1:0] Write_data,
  input  logic [4:0]      Rs1,
  input  logic [4:0]      Rs2,
  output logic            Fwd_hit1,
  output logic            Fwd_hit2,
  output logic [XLEN-1:0] Fwd_data1,
  output logic [XLEN-1:0] Fwd_data2,
  output logic [CNTW-1:0] Wb_count
);

  logic [1:0]      count;
  logic            rd_ptr;
  logic            wr_ptr;
  logic            q_rw   [2];
  logic [4:0]      q_rd   [2];
  logic [XLEN-1:0] q_data [2];

  logic            push;
  logic            pop;
  logic            head_wr;
  logic            tail_idx;

  assign In_ready = rst_n && ((count != 2'd2) || !Hold);
  assign push     = In_valid && In_ready;
  assign pop      = (count != 2'd0) && !Hold;
  assign head_wr  = q_rw[rd_ptr] && (q_rd[rd_ptr] != 5'd0);
  assign tail_idx = ~wr_ptr;

  // Storage carries no reset; occupancy is tracked solely by count and the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rw[wr_ptr]   <= In_RegWrite;
      q_rd[wr_ptr]   <= In_Rd;
      q_data[wr_ptr] <= In_MemtoReg ? In_Load_data : In_ALU_result;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      RegWrite   <= 1'b0;
      Rd         <= 5'd0;
      Write_data <= '0;
      Wb_count   <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (pop) begin
        RegWrite   <= head_wr;
        Rd         <= q_rd[rd_ptr];
        Write_data <= q_data[rd_ptr];
        if (head_wr) Wb_count <= Wb_count + 1'b1;
      end else begin
        RegWrite   <= 1'b0;
        Rd         <= 5'd0;
        Write_data <= '0;
      end
    end
  end

  // Youngest-first search: tail, head, then the write-port register.
  function automatic logic [XLEN:0] lookup(input logic [4:0] rs);
    logic [XLEN:0] res;
    res = '0;
    if (rs != 5'd0 && rst_n) begin
      if (count != 2'd0 && q_rw[tail_idx] && q_rd[tail_idx] == rs)
        res = {1'b1, q_data[tail_idx]};
      else if (count != 2'd0 && q_rw[rd_ptr] && q_rd[rd_ptr] == rs)
        res = {1'b1, q_data[rd_ptr]};
      else if (RegWrite && Rd == rs)
        res = {1'b1, Write_data};
    end
    return res;
  endfunction

  always_comb begin
    {Fwd_hit1, Fwd_data1} = lookup(Rs1);
    {Fwd_hit2, Fwd_data2} = lookup(Rs2);
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with hand-computed expectations; counter narrowed to exercise wrap.
module tb_writeback_unit;

  localparam int XLEN = 32;
  localparam int CNTW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            In_valid;
  logic            In_ready;
  logic            In_RegWrite;
  logic            In_MemtoReg;
  logic [4:0]      In_Rd;
  logic [XLEN-1:0] In_ALU_result;
  logic [XLEN-1:0] In_Load_data;
  logic            Hold;
  logic            RegWrite;
  logic [4:0]      Rd;
  logic [XLEN-1:0] Write_data;
  logic [4:0]      Rs1;
  logic [4:0]      Rs2;
  logic            Fwd_hit1;
  logic            Fwd_hit2;
  logic [XLEN-1:0] Fwd_data1;
  logic [XLEN-1:0] Fwd_data2;
  logic [CNTW-1:0] Wb_count;

  int n_cmp = 0;
  int n_bad = 0;

  writeback_unit #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .In_valid(In_valid), .In_ready(In_ready),
    .In_RegWrite(In_RegWrite), .In_MemtoReg(In_MemtoReg), .In_Rd(In_Rd),
    .In_ALU_result(In_ALU_result), .In_Load_data(In_Load_data),
    .Hold(Hold), .RegWrite(RegWrite), .Rd(Rd), .Write_data(Write_data),
    .Rs1(Rs1), .Rs2(Rs2), .Fwd_hit1(Fwd_hit1), .Fwd_hit2(Fwd_hit2),
    .Fwd_data1(Fwd_data1), .Fwd_data2(Fwd_data2), .Wb_count(Wb_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic rw, input logic m2r, input logic [4:0] rd,
                       input logic [XLEN-1:0] alu, input logic [XLEN-1:0] ld);
    In_valid = v; In_RegWrite = rw; In_MemtoReg = m2r; In_Rd = rd;
    In_ALU_result = alu; In_Load_data = ld;
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; Hold = 1'b0; Rs1 = 5'd0; Rs2 = 5'd0;
    offer(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);

    // Reset behaviour
    tick(); tick();
    check("rst_ready", In_ready, 0);
    Rs1 = 5'd0;
    check("rst_hit1", Fwd_hit1, 0);
    check("rst_regwrite", RegWrite, 0);
    check("rst_rd", Rd, 0);
    check("rst_wdata", Write_data, 0);
    check("rst_wbcount", Wb_count, 0);
    rst_n = 1'b1; #1;
    check("ready_after_rst", In_ready, 1);

    // Single write, one-cycle latency, one-cycle pulse
    offer(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    tick();
    offer(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    Rs1 = 5'd5; #1;
    check("single_not_yet", RegWrite, 0);
    check("single_fwd_hit", Fwd_hit1, 1);
    check("single_fwd_data", Fwd_data1, 32'h1234);
    tick();
    check("single_regwrite", RegWrite, 1);
    check("single_rd", Rd, 5);
    check("single_wdata", Write_data, 32'h1234);
    check("single_wbcount", Wb_count, 1);
    tick();
    check("single_pulse_end", RegWrite, 0);
    check("single_rd_clear", Rd, 0);

    // x0 suppression
    offer(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFF, 32'h0);
    tick();
    offer(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    Rs1 = 5'd0; #1;
    check("x0_fwd_hit", Fwd_hit1, 0);
    tick();
    check("x0_regwrite", RegWrite, 0);
    check("x0_wbcount", Wb_count, 1);

    // Load select
    offer(1'b1, 1'b1, 1'b1, 5'd9, 32'hBEEF, 32'hDEAD);
    tick();
    offer(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    tick();
    check("load_regwrite", RegWrite, 1);
    check("load_wdata", Write_data, 32'hDEAD);
    check("load_wbcount", Wb_count, 2);

    // Backpressure, then full-FIFO push+pop on release
    Hold = 1'b1;
    offer(1'b1, 1'b1, 1'b0, 5'd1, 32'h11, 32'h0);
    check("bp_ready0", In_ready, 1);
    tick();
    offer(1'b1, 1'b1, 1'b0, 5'd2, 32'h22, 32'h0);
    check("bp_ready1", In_ready, 1);
    tick();
    offer(1'b1, 1'b1, 1'b0, 5'd3, 32'h33, 32'h0);
    check("bp_ready_full", In_ready, 0);
    tick();
    check("bp_hold_regwrite", RegWrite, 0);
    Rs1 = 5'd1; Rs2 = 5'd2; #1;
    check("bp_fwd1", Fwd_data1, 32'h11);
    check("bp_fwd2", Fwd_data2, 32'h22);
    Hold = 1'b0; #1;
    check("bp_ready_release", In_ready, 1);
    tick();
    offer(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    check("bp_w1_rd", Rd, 1);
    check("bp_w1_data", Write_data, 32'h11);
    tick();
    check("bp_w2_rd", Rd, 2);
    check("bp_w2_regwrite", RegWrite, 1);
    tick();
    check("bp_w3_rd", Rd, 3);
    check("bp_w3_data", Write_data, 32'h33);
    Rs1 = 5'd3; #1;
    check("bp_fwd_port_hit", Fwd_hit1, 1);
    check("bp_fwd_port_data", Fwd_data1, 32'h33);
    check("bp_wbcount", Wb_count, 5);

    // Forwarding priority with both entries targeting r7
    Hold = 1'b1;
    offer(1'b1, 1'b1, 1'b0, 5'd7, 32'hA, 32'h0);
    tick();
    check("bp_drained", RegWrite, 0);
    offer(1'b1, 1'b1, 1'b0, 5'd7, 32'hB, 32'h0);
    tick();
    offer(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    Rs1 = 5'd7; Rs2 = 5'd6; #1;
    check("prio_hit1", Fwd_hit1, 1);
    check("prio_data1", Fwd_data1, 32'hB);
    check("prio_miss2", Fwd_hit2, 0);
    check("prio_miss2_data", Fwd_data2, 0);

    // Reset mid-drain with a full FIFO
    rst_n = 1'b0; #1;
    check("rst_mid_ready", In_ready, 0);
    check("rst_mid_hit", Fwd_hit1, 0);
    tick();
    check("rst_mid_regwrite", RegWrite, 0);
    check("rst_mid_wbcount", Wb_count, 0);
    rst_n = 1'b1; Hold = 1'b0; #1;
    check("rst_mid_ready_after", In_ready, 1);
    check("rst_mid_empty_fwd", Fwd_hit1, 0);
    tick();
    check("rst_mid_no_write", RegWrite, 0);

    // Streaming nine writes wraps the 3-bit counter
    for (int i = 0; i < 9; i++) begin
      offer(1'b1, 1'b1, 1'b0, 5'(i + 1), 32'(i + 100), 32'h0);
      tick();
    end
    offer(1'b0, 1'b0, 1'b0, 5'd0, '0, '0);
    check("wrap_eight", Wb_count, 0);
    check("stream_rd8", Rd, 8);
    tick();
    check("wrap_nine", Wb_count, 1);
    check("stream_last_data", Write_data, 32'd108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
